ddr_tx_gearbox: RTL and testbench
=================================

DDR_TX_GEARBOX -- requirements
Module: ddr_tx_gearbox

Interface
REQ-001 Parameter WIDTH, default 8, parallel word width; SHALL be even, 4..32; other values SHALL fail elaboration.
REQ-002 Parameter IDLE_BIT, default 1'b0, value driven on D0/D1 when no word is being sent.
REQ-003 Parameter LSB_FIRST, default 1, 1 = bit 0 sent first, 0 = bit WIDTH-1 sent first.
REQ-004 SCLK  input  1  single clock; all state SHALL change on posedge SCLK only, except reset.
REQ-005 RSTN  input  1  reset, asynchronous assert, active-low; the block SHALL be held in reset while RSTN=0.
REQ-006 DATA  input  WIDTH  parallel word, sampled when VALID&READY at posedge SCLK.
REQ-007 VALID  input  1  upstream word-available qualifier.
REQ-008 READY  output  1  block can accept a word this cycle.
REQ-009 D0  output  1  earlier-in-time bit of the current pair; drives the ODDRX1F D0 input.
REQ-010 D1  output  1  later-in-time bit of the current pair; drives the ODDRX1F D1 input.
REQ-011 BUSY  output  1  high while D0/D1 carry word data.
REQ-012 UNDERRUN  output  1  one-cycle pulse marking a data-to-idle gap.

Function
REQ-013 Storage SHALL be one shift register (active word) plus one holding register (skid entry), each with an occupancy flag.
REQ-014 The block SHALL track the active word with a pair counter of width clog2(WIDTH/2), counting 0..WIDTH/2-1.
REQ-015 Bit order per word: pair i SHALL be D0=bit 2i, D1=bit 2i+1 when LSB_FIRST=1; D0=bit WIDTH-1-2i, D1=bit WIDTH-2-2i when LSB_FIRST=0.
REQ-016 D0, D1, BUSY and UNDERRUN SHALL be registered outputs; READY SHALL be (holding register empty) AND (ready-enable flop = 1).
REQ-017 States: IDLE (shifter empty) and SEND (shifter full); the holding flag is independent of state.
REQ-018 IDLE, accept (VALID&READY at edge N): the word SHALL load directly into the shifter, giving pair 0 on D0/D1 and BUSY=1 after edge N, state SEND.
REQ-019 SEND: pair i SHALL appear after edge N+i; the last pair SHALL appear after edge N+WIDTH/2-1.
REQ-020 SEND, edge with an accept and the counter not at last pair: the word SHALL go to the holding register and READY SHALL fall.
REQ-021 SEND, last-pair edge with the holding register full: the held word SHALL load into the shifter (pair 0 out next cycle, no gap) and the holding register SHALL empty.
REQ-022 SEND, last-pair edge with the holding register empty and VALID=1: DATA SHALL load directly into the shifter, gapless, and READY SHALL stay 1.
REQ-023 Simultaneous accept while the held word moves to the shifter is impossible, because READY=0 while the holding register is full.
REQ-024 SEND, last-pair edge with no word available: state SHALL go to IDLE, D0=D1=IDLE_BIT, BUSY=0, and UNDERRUN=1 for exactly one cycle.
REQ-025 VALID without READY SHALL be ignored; DATA SHALL not be sampled.
REQ-026 Throughput SHALL be one word per WIDTH/2 cycles sustained, with zero idle pairs between back-to-back words.

Reset
REQ-027 RSTN=0 SHALL immediately force D0=D1=IDLE_BIT, BUSY=0, UNDERRUN=0, READY=0, both registers empty, counter=0, and state IDLE.
REQ-028 The ready-enable flop SHALL reset to 0 and set on the first posedge SCLK after RSTN=1, so READY=1 after that edge.
REQ-029 Reset mid-word SHALL discard the active and held words with no partial output after release; the first post-reset word SHALL start at pair 0.

Verification
REQ-030 WIDTH=8, LSB_FIRST=1, DATA=8'hB4 single accept -> D0/D1 pairs (0,0),(1,0),(1,1),(0,1) over 4 cycles, then idle 0/0, BUSY 1 for 4 cycles, and one UNDERRUN pulse.
REQ-031 LSB_FIRST=0, DATA=8'hB4 -> pairs (1,0),(1,1),(0,1),(0,0).
REQ-032 VALID held high with words 8'h01, 8'h02, 8'h03 -> 12 consecutive data pairs, BUSY never drops, UNDERRUN only after the last pair.
REQ-033 Second word offered at pair 1 of the first -> held (READY=0 for 3 cycles), sent gaplessly, READY=1 again the cycle after the load.
REQ-034 RSTN pulled low at pair 2 with the holding register full -> outputs IDLE_BIT immediately, READY=0; after release READY=1 one edge later, no stale pairs.
REQ-035 IDLE_BIT=1 build -> D0=D1=1 in reset and between words; WIDTH=6 and WIDTH=32 builds complete 3 and 16 pairs per word.

Source files
------------

// File: rtl/ddr_tx_gearbox.sv
// Serialises WIDTH-bit words into D0/D1 pairs for an ODDRX1F; pair 0 appears one edge after accept.
// One skid entry: READY drops only while it is occupied, so back-to-back words stream with no gap.
module ddr_tx_gearbox #(
  parameter int   WIDTH     = 8,
  parameter logic IDLE_BIT  = 1'b0,
  parameter bit   LSB_FIRST = 1'b1
) (
  input  logic             SCLK,
  input  logic             RSTN,
  input  logic [WIDTH-1:0] DATA,
  input  logic             VALID,
  output logic             READY,
  output logic             D0,
  output logic             D1,
  output logic             BUSY,
  output logic             UNDERRUN
);
  localparam int PAIRS = WIDTH / 2;
  localparam int CW    = $clog2(PAIRS);
  localparam logic [CW-1:0] LAST = CW'(PAIRS - 1);

  if (WIDTH < 4 || WIDTH > 32 || (WIDTH % 2) != 0) begin : g_bad_width
    $error("ddr_tx_gearbox: WIDTH must be even and within 4..32");
  end

  typedef enum logic {IDLE, SEND} state_t;

  state_t           state;
  logic [WIDTH-1:0] sh_q;
  logic [WIDTH-1:0] hold_q;
  logic             hold_vld;
  logic             rdy_en;
  logic [CW-1:0]    cnt;

  logic             accept;
  logic             last;
  logic [WIDTH-1:0] ld_word;
  logic [WIDTH-1:0] ld_rest;
  logic [WIDTH-1:0] sh_rest;
  logic             ld_d0, ld_d1, sh_d0, sh_d1;

  assign READY   = ~hold_vld & rdy_en;
  assign accept  = VALID & READY;
  assign last    = (cnt == LAST);
  assign ld_word = hold_vld ? hold_q : DATA;

  // The shifter holds only the pairs not yet sent; its first pair goes straight to D0/D1 on load.
  if (LSB_FIRST) begin : g_lsb
    assign ld_d0   = ld_word[0];
    assign ld_d1   = ld_word[1];
    assign ld_rest = ld_word >> 2;
    assign sh_d0   = sh_q[0];
    assign sh_d1   = sh_q[1];
    assign sh_rest = sh_q >> 2;
  end else begin : g_msb
    assign ld_d0   = ld_word[WIDTH-1];
    assign ld_d1   = ld_word[WIDTH-2];
    assign ld_rest = ld_word << 2;
    assign sh_d0   = sh_q[WIDTH-1];
    assign sh_d1   = sh_q[WIDTH-2];
    assign sh_rest = sh_q << 2;
  end

  always_ff @(posedge SCLK or negedge RSTN) begin
    if (!RSTN) begin
      state    <= IDLE;
      sh_q     <= '0;
      hold_q   <= '0;
      hold_vld <= 1'b0;
      rdy_en   <= 1'b0;
      cnt      <= '0;
      D0       <= IDLE_BIT;
      D1       <= IDLE_BIT;
      BUSY     <= 1'b0;
      UNDERRUN <= 1'b0;
    end else begin
      rdy_en   <= 1'b1;
      UNDERRUN <= 1'b0;
      if (state == SEND && !last) begin
        D0   <= sh_d0;
        D1   <= sh_d1;
        sh_q <= sh_rest;
        cnt  <= cnt + CW'(1);
        if (accept) begin
          hold_q   <= DATA;
          hold_vld <= 1'b1;
        end
      end else if (hold_vld || accept) begin
        // Start from IDLE or reload on the last-pair edge: held word has priority over DATA.
        state    <= SEND;
        D0       <= ld_d0;
        D1       <= ld_d1;
        sh_q     <= ld_rest;
        cnt      <= '0;
        BUSY     <= 1'b1;
        hold_vld <= 1'b0;
      end else begin
        if (state == SEND) UNDERRUN <= 1'b1;
        state <= IDLE;
        D0    <= IDLE_BIT;
        D1    <= IDLE_BIT;
        BUSY  <= 1'b0;
        cnt   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ddr_tx_gearbox.sv
// Directed bench for ddr_tx_gearbox: 8-bit LSB/MSB builds share stimulus, 6- and 32-bit builds share a second set.
module tb_ddr_tx_gearbox;
  logic        sclk;
  logic        rstn;
  logic [7:0]  data_ab;
  logic        valid_ab;
  logic [31:0] data_cd;
  logic        valid_cd;

  logic ready_a, d0_a, d1_a, busy_a, und_a;
  logic ready_b, d0_b, d1_b, busy_b, und_b;
  logic ready_c, d0_c, d1_c, busy_c, und_c;
  logic ready_d, d0_d, d1_d, busy_d, und_d;

  int n_chk  = 0;
  int n_fail = 0;

  ddr_tx_gearbox #(.WIDTH(8), .IDLE_BIT(1'b0), .LSB_FIRST(1'b1)) u_a (
    .SCLK(sclk), .RSTN(rstn), .DATA(data_ab), .VALID(valid_ab), .READY(ready_a),
    .D0(d0_a), .D1(d1_a), .BUSY(busy_a), .UNDERRUN(und_a));

  ddr_tx_gearbox #(.WIDTH(8), .IDLE_BIT(1'b1), .LSB_FIRST(1'b0)) u_b (
    .SCLK(sclk), .RSTN(rstn), .DATA(data_ab), .VALID(valid_ab), .READY(ready_b),
    .D0(d0_b), .D1(d1_b), .BUSY(busy_b), .UNDERRUN(und_b));

  ddr_tx_gearbox #(.WIDTH(6), .IDLE_BIT(1'b1), .LSB_FIRST(1'b1)) u_c (
    .SCLK(sclk), .RSTN(rstn), .DATA(data_cd[5:0]), .VALID(valid_cd), .READY(ready_c),
    .D0(d0_c), .D1(d1_c), .BUSY(busy_c), .UNDERRUN(und_c));

  ddr_tx_gearbox #(.WIDTH(32), .IDLE_BIT(1'b0), .LSB_FIRST(1'b0)) u_d (
    .SCLK(sclk), .RSTN(rstn), .DATA(data_cd), .VALID(valid_cd), .READY(ready_d),
    .D0(d0_d), .D1(d1_d), .BUSY(busy_d), .UNDERRUN(und_d));

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  // Pair i as {D0,D1}, straight from the bit-order definition.
  function automatic logic [1:0] exp_pair(input logic [31:0] w, input int width, input int i, input bit lsb);
    if (lsb) return {w[2*i], w[2*i+1]};
    return {w[width-1-2*i], w[width-2-2*i]};
  endfunction

  task automatic check_idle_ab(input string tag);
    check({tag, "_pair_a"}, {30'd0, d0_a, d1_a}, 32'd0);
    check({tag, "_pair_b"}, {30'd0, d0_b, d1_b}, 32'd3);
    check({tag, "_busy_a"}, {31'd0, busy_a}, 32'd0);
    check({tag, "_busy_b"}, {31'd0, busy_b}, 32'd0);
  endtask

  task automatic send_one(input logic [7:0] w);
    data_ab  = w;
    valid_ab = 1'b1;
    tick();
    valid_ab = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("one_pair_a", {30'd0, d0_a, d1_a}, {30'd0, exp_pair({24'd0, w}, 8, i, 1'b1)});
      check("one_pair_b", {30'd0, d0_b, d1_b}, {30'd0, exp_pair({24'd0, w}, 8, i, 1'b0)});
      check("one_busy", {31'd0, busy_a}, 32'd1);
      check("one_und", {31'd0, und_a}, 32'd0);
      check("one_ready", {31'd0, ready_a}, 32'd1);
      tick();
    end
    check_idle_ab("one_end");
    check("one_und_a", {31'd0, und_a}, 32'd1);
    check("one_und_b", {31'd0, und_b}, 32'd1);
    tick();
    check("one_und_clr", {31'd0, und_a}, 32'd0);
    check("one_ready_end", {31'd0, ready_a}, 32'd1);
  endtask

  initial begin
    logic [7:0]  words [3];
    logic [31:0] wc;
    int          idx;
    bit          acc;

    words    = '{8'h01, 8'h02, 8'h03};
    rstn     = 1'b0;
    valid_ab = 1'b0;
    valid_cd = 1'b0;
    data_ab  = '0;
    data_cd  = '0;

    // Reset state
    tick();
    check_idle_ab("rst");
    check("rst_pair_c", {30'd0, d0_c, d1_c}, 32'd3);
    check("rst_und", {31'd0, und_a}, 32'd0);
    check("rst_ready", {31'd0, ready_a}, 32'd0);
    #3 rstn = 1'b1;
    #1 check("ready_pre_edge", {31'd0, ready_a}, 32'd0);
    tick();
    check("ready_post_edge", {31'd0, ready_a}, 32'd1);
    check("ready_post_edge_c", {31'd0, ready_c}, 32'd1);

    // Single word, both bit orders
    send_one(8'hB4);

    // Back-to-back stream with VALID held high
    idx      = 0;
    data_ab  = words[0];
    valid_ab = 1'b1;
    for (int c = 0; c < 12; c++) begin
      acc = valid_ab && ready_a;
      tick();
      if (acc) begin
        idx++;
        if (idx < 3) data_ab = words[idx];
        else valid_ab = 1'b0;
      end
      check("b2b_pair_a", {30'd0, d0_a, d1_a}, {30'd0, exp_pair({24'd0, words[c/4]}, 8, c % 4, 1'b1)});
      check("b2b_pair_b", {30'd0, d0_b, d1_b}, {30'd0, exp_pair({24'd0, words[c/4]}, 8, c % 4, 1'b0)});
      check("b2b_busy", {31'd0, busy_a}, 32'd1);
      check("b2b_und", {31'd0, und_a}, 32'd0);
    end
    check("b2b_accepts", idx, 32'd3);
    tick();
    check("b2b_und_end", {31'd0, und_a}, 32'd1);
    check_idle_ab("b2b_end");

    // Second word offered during pair 0 lands in the skid entry
    data_ab  = 8'hC3;
    valid_ab = 1'b1;
    tick();
    check("skid_pair0", {30'd0, d0_a, d1_a}, {30'd0, exp_pair(32'hC3, 8, 0, 1'b1)});
    check("skid_ready0", {31'd0, ready_a}, 32'd1);
    data_ab = 8'h96;
    tick();
    valid_ab = 1'b0;
    for (int i = 1; i < 4; i++) begin
      check("skid_pair_first", {30'd0, d0_a, d1_a}, {30'd0, exp_pair(32'hC3, 8, i, 1'b1)});
      check("skid_ready_low", {31'd0, ready_a}, 32'd0);
      tick();
    end
    check("skid_ready_back", {31'd0, ready_a}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      check("skid_pair_second", {30'd0, d0_a, d1_a}, {30'd0, exp_pair(32'h96, 8, i, 1'b1)});
      check("skid_busy", {31'd0, busy_a}, 32'd1);
      check("skid_und", {31'd0, und_a}, 32'd0);
      tick();
    end
    check("skid_und_end", {31'd0, und_a}, 32'd1);
    tick();

    // Reset at pair 2 with the skid entry full
    data_ab  = 8'hC3;
    valid_ab = 1'b1;
    tick();
    data_ab = 8'h96;
    tick();
    valid_ab = 1'b0;
    tick();
    check("mid_pair2", {30'd0, d0_a, d1_a}, {30'd0, exp_pair(32'hC3, 8, 2, 1'b1)});
    check("mid_ready_held", {31'd0, ready_a}, 32'd0);
    #2 rstn = 1'b0;
    #1 check_idle_ab("mid_rst");
    check("mid_rst_ready", {31'd0, ready_a}, 32'd0);
    tick();
    tick();
    check_idle_ab("mid_rst_hold");
    #2 rstn = 1'b1;
    #1 check("mid_rel_ready", {31'd0, ready_a}, 32'd0);
    tick();
    check("mid_rel_ready_edge", {31'd0, ready_a}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      check_idle_ab("mid_stale");
      check("mid_stale_und", {31'd0, und_a}, 32'd0);
      tick();
    end
    send_one(8'h3C);

    // 6-bit and 32-bit builds
    data_cd  = 32'hA5C3_0F96;
    wc       = {26'd0, data_cd[5:0]};
    valid_cd = 1'b1;
    tick();
    valid_cd = 1'b0;
    for (int c = 0; c < 17; c++) begin
      check("w6_busy", {31'd0, busy_c}, {31'd0, c < 3});
      check("w6_und", {31'd0, und_c}, {31'd0, c == 3});
      if (c < 3) check("w6_pair", {30'd0, d0_c, d1_c}, {30'd0, exp_pair(wc, 6, c, 1'b1)});
      else check("w6_idle", {30'd0, d0_c, d1_c}, 32'd3);
      check("w32_busy", {31'd0, busy_d}, {31'd0, c < 16});
      check("w32_und", {31'd0, und_d}, {31'd0, c == 16});
      if (c < 16) check("w32_pair", {30'd0, d0_d, d1_d}, {30'd0, exp_pair(32'hA5C3_0F96, 32, c, 1'b0)});
      else check("w32_idle", {30'd0, d0_d, d1_d}, 32'd0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
